// File: rtl/bench_trig_gen.sv
// Periodic trigger plus one delayed serial frame (start bit + MSB-first word) per period.
// Optional BENCH_PRBS_EN: payload words come from a PRBS-31 LFSR instead of an incrementing counter.
module bench_trig_gen #(
    parameter int                    TRIG_PERIOD = 1000,
    parameter int                    TRIG_WIDTH  = 4,
    parameter int                    DATA_DELAY  = 10,
    parameter int                    DATA_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] INIT_WORD   = '0
) (
    input  logic clk,
    input  logic rst,
    output logic trig,
    output logic data_out
);

    localparam int CW = (TRIG_PERIOD > 1) ? $clog2(TRIG_PERIOD) : 1;
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] CNT_LAST   = CW'(TRIG_PERIOD - 1);
    localparam logic [CW-1:0] TRIG_HIGH  = CW'(TRIG_WIDTH);
    localparam logic [CW-1:0] DATA_START = CW'(DATA_DELAY);
    localparam logic [IW-1:0] IDX_TOP    = IW'(DATA_WIDTH - 1);

    // The frame must finish (including STOP) before the next launch point comes round.
    if (TRIG_PERIOD < DATA_DELAY + DATA_WIDTH + 2) begin : g_param_check
        $error("bench_trig_gen: TRIG_PERIOD too short for DATA_DELAY+DATA_WIDTH+2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STOP  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           bit_idx;
    logic [IW-1:0]           bit_idx_nxt;
    logic [DATA_WIDTH-1:0]   word;
    logic                    data_nxt;
    logic                    word_adv;

    // Period counter and trigger: independent of the frame machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            trig <= 1'b0;
        end else begin
            cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
            trig <= (cnt < TRIG_HIGH);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_idx  <= '0;
            data_out <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_idx  <= bit_idx_nxt;
            data_out <= data_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_idx_nxt = bit_idx;
        data_nxt    = 1'b0;
        word_adv    = 1'b0;
        case (state)
            IDLE: begin
                if (cnt == DATA_START) begin
                    data_nxt    = 1'b1;
                    bit_idx_nxt = IDX_TOP;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                data_nxt = word[bit_idx];
                if (bit_idx == '0) begin
                    state_nxt = STOP;
                end else begin
                    bit_idx_nxt = bit_idx - IW'(1);
                end
            end
            STOP: begin
                word_adv  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef BENCH_PRBS_EN
    logic [30:0] lfsr;

    function automatic logic [30:0] prbs_adv(input logic [30:0] s);
        logic [30:0] r;
        r = s;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            r = {r[29:0], r[30] ^ r[27]};
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 31'h7FFF_FFFF;
        end else if (word_adv) begin
            lfsr <= prbs_adv(lfsr);
        end
    end

    assign word = DATA_WIDTH'({1'b0, lfsr});
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            word <= INIT_WORD;
        end else if (word_adv) begin
            word <= word + DATA_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_bench_trig_gen.sv
// Directed bench for bench_trig_gen: three instances (nominal, wrap, minimum-period boundary),
// reset, mid-frame reset abort, and restart from the initial word.
module tb_bench_trig_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic trig_a, data_a, trig_b, data_b, trig_c, data_c;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bench_trig_gen #(
        .TRIG_PERIOD(40), .TRIG_WIDTH(4), .DATA_DELAY(10), .DATA_WIDTH(16), .INIT_WORD(16'hA5A5)
    ) dut_a (
        .clk(clk), .rst(rst), .trig(trig_a), .data_out(data_a)
    );

    bench_trig_gen #(
        .TRIG_PERIOD(40), .TRIG_WIDTH(4), .DATA_DELAY(10), .DATA_WIDTH(16), .INIT_WORD(16'hFFFF)
    ) dut_b (
        .clk(clk), .rst(rst), .trig(trig_b), .data_out(data_b)
    );

    bench_trig_gen #(
        .TRIG_PERIOD(13), .TRIG_WIDTH(4), .DATA_DELAY(10), .DATA_WIDTH(1), .INIT_WORD(1'b0)
    ) dut_c (
        .clk(clk), .rst(rst), .trig(trig_c), .data_out(data_c)
    );

    function automatic logic [31:0] width_mask(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // Payload of frame k after reset.
    function automatic logic [31:0] word_of(input logic [31:0] init, input int w, input int k);
`ifdef BENCH_PRBS_EN
        logic [30:0] s;
        logic [31:0] e;
        s = 31'h7FFF_FFFF;
        for (int i = 0; i < k * w; i++) begin
            s = {s[29:0], s[30] ^ s[27]};
        end
        e = {1'b0, s};
        return e & width_mask(w) & (init | ~init);
`else
        return (init + 32'(k)) & width_mask(w);
`endif
    endfunction

    // Trigger high on the first 4 edges of each period, edges counted from 1 after release.
    function automatic logic exp_trig(input int p, input int e);
        return ((e - 1) % p) < 4;
    endfunction

    // Start bit at period position 11, payload MSB first at positions 12..11+w, else 0.
    function automatic logic exp_data(input logic [31:0] init, input int w, input int p, input int e);
        int          k;
        int          pos;
        logic [31:0] wd;
        k   = (e - 1) / p;
        pos = (e - 1) % p + 1;
        wd  = word_of(init, w, k);
        if (pos == 11) return 1'b1;
        if (pos >= 12 && pos <= 11 + w) return wd[11 + w - pos];
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input int e, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s edge=%0d observed=%b expected=%b", tag, e, obs, exp);
            $error("check %s edge=%0d observed=%b expected=%b", tag, e, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_edge(input int e);
        chk("trig_a", e, trig_a, exp_trig(40, e));
        chk("trig_b", e, trig_b, exp_trig(40, e));
        chk("trig_c", e, trig_c, exp_trig(13, e));
        chk("data_a", e, data_a, exp_data(32'h0000_A5A5, 16, 40, e));
        chk("data_b", e, data_b, exp_data(32'h0000_FFFF, 16, 40, e));
        chk("data_c", e, data_c, exp_data(32'h0000_0000, 1, 13, e));
    endtask

    task automatic check_all_zero(input string tag, input int e);
        chk({tag, "_trig_a"}, e, trig_a, 1'b0);
        chk({tag, "_data_a"}, e, data_a, 1'b0);
        chk({tag, "_trig_b"}, e, trig_b, 1'b0);
        chk({tag, "_data_b"}, e, data_b, 1'b0);
        chk({tag, "_trig_c"}, e, trig_c, 1'b0);
        chk({tag, "_data_c"}, e, data_c, 1'b0);
    endtask

    initial begin
        // Reset held for three edges: all outputs low.
        rst = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check_all_zero("reset", i);
        end
        rst = 1'b0;

        // Two and a bit periods of dut_a/dut_b, over seven periods of dut_c.
        for (int e = 1; e <= 96; e++) begin
            step();
            check_edge(e);
        end

        // Edge 96 carried dut_a's fifth payload bit; abort the frame with a one-cycle reset.
        rst = 1'b1;
        step();
        check_all_zero("midrst", 97);
        rst = 1'b0;

        // Restart must replay the first sequence, payload from the initial word again.
        for (int e = 1; e <= 45; e++) begin
            step();
            check_edge(e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
